mem_access: RTL and testbench

- Memory-access/writeback stage of the multi-cycle RV32I core, directly downstream of the ALU.
- Consumes the ALU result `y` and store-data passthrough `pass`, along with the instruction word and instruction type.
- For `LTYPE`/`STYPE` it runs a single-outstanding request/acknowledge transaction on the data-memory port, with byte lanes and load extension.
- For `RTYPE`/`ITYPE` it forwards the ALU result to register writeback. `done_o`/`busy_o` let the stage sequencer stall.

---
 rtl/mem_access.sv | 184 ++++++++++++++++++
 tb/tb_mem_access.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access.sv
// rtl/mem_access.sv - RV32I memory-access/writeback stage with a single-outstanding data-memory port
`ifndef RTYPE
`define RTYPE 5'b00001
`endif
`ifndef ITYPE
`define ITYPE 5'b00010
`endif
`ifndef STYPE
`define STYPE 5'b00100
`endif
`ifndef UTYPE
`define UTYPE 5'b01000
`endif
`ifndef LTYPE
`define LTYPE 5'b10000
`endif

module mem_access #(
  parameter logic [2:0]  EXEC_STAGE = 3'd4,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  stage_i,
  input  logic [31:0] ir_i,
  input  logic [4:0]  itype_i,
  input  logic [31:0] y_i,
  input  logic [31:0] pass_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_wstrb_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  output logic        wb_en_o,
  output logic [4:0]  wb_rd_o,
  output logic [31:0] wb_data_o,
  output logic        done_o,
  output logic        busy_o,
  output logic        err_o
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  logic [0:0]    state;
  logic          served;
  logic [CW-1:0] cnt;
  logic [2:0]    f3_q;
  logic [4:0]    rd_q;
  logic [1:0]    off_q;

  logic [2:0]  f3;
  logic [4:0]  rd;
  logic        is_alu, is_load, is_store, illegal, misaligned;
  logic [31:0] wdata_n, rshift, load_val;
  logic [3:0]  wstrb_n;
  logic        unused_ir;

  assign f3        = ir_i[14:12];
  assign rd        = ir_i[11:7];
  assign unused_ir = &{1'b0, ir_i[31:15], ir_i[6:0]};
  assign is_alu    = (itype_i == `RTYPE) || (itype_i == `ITYPE);
  assign is_load   = (itype_i == `LTYPE);
  assign is_store  = (itype_i == `STYPE);
  assign illegal   = is_load ? (f3 == 3'b011 || f3[2:1] == 2'b11) : (f3 >= 3'b011);
  assign misaligned = (f3[1:0] == 2'b01 && y_i[0]) || (f3[1:0] == 2'b10 && y_i[1:0] != 2'b00);
  assign busy_o    = (state == WAIT);

  // Store data is replicated so the memory can pick any lane with the strobes alone.
  always_comb begin
    wdata_n = pass_i;
    wstrb_n = 4'b1111;
    case (f3[1:0])
      2'b00: begin
        wdata_n = {4{pass_i[7:0]}};
        wstrb_n = 4'b0001 << y_i[1:0];
      end
      2'b01: begin
        wdata_n = {2{pass_i[15:0]}};
        wstrb_n = 4'b0011 << y_i[1:0];
      end
      default: begin
        wdata_n = pass_i;
        wstrb_n = 4'b1111;
      end
    endcase
    if (!is_store) wstrb_n = 4'b0000;
  end

  assign rshift = mem_rdata_i >> {off_q, 3'b000};

  always_comb begin
    load_val = mem_rdata_i;
    case (f3_q)
      3'b000:  load_val = {{24{rshift[7]}}, rshift[7:0]};
      3'b001:  load_val = {{16{rshift[15]}}, rshift[15:0]};
      3'b100:  load_val = {24'h0, rshift[7:0]};
      3'b101:  load_val = {16'h0, rshift[15:0]};
      default: load_val = mem_rdata_i;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      served      <= 1'b0;
      cnt         <= '0;
      f3_q        <= 3'b000;
      rd_q        <= 5'd0;
      off_q       <= 2'b00;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= 32'h0;
      mem_wdata_o <= 32'h0;
      mem_wstrb_o <= 4'b0000;
      wb_en_o     <= 1'b0;
      wb_rd_o     <= 5'd0;
      wb_data_o   <= 32'h0;
      done_o      <= 1'b0;
      err_o       <= 1'b0;
    end else begin
      wb_en_o <= 1'b0;
      done_o  <= 1'b0;
      err_o   <= 1'b0;
      if (stage_i != EXEC_STAGE) served <= 1'b0;
      case (state)
        IDLE: begin
          if (stage_i == EXEC_STAGE && !served) begin
            served <= 1'b1;
            if (is_alu) begin
              wb_data_o <= y_i;
              wb_rd_o   <= rd;
              wb_en_o   <= (rd != 5'd0);
              done_o    <= 1'b1;
            end else if (is_load || is_store) begin
              if (illegal || misaligned) begin
                err_o  <= 1'b1;
                done_o <= 1'b1;
              end else begin
                mem_req_o   <= 1'b1;
                mem_we_o    <= is_store;
                mem_addr_o  <= {y_i[31:2], 2'b00};
                mem_wdata_o <= wdata_n;
                mem_wstrb_o <= wstrb_n;
                f3_q        <= f3;
                rd_q        <= rd;
                off_q       <= y_i[1:0];
                cnt         <= '0;
                state       <= WAIT;
              end
            end else begin
              done_o <= 1'b1;
            end
          end
        end
        default: begin
          // An ack on the same edge the counter would expire still completes normally.
          if (mem_ack_i) begin
            mem_req_o <= 1'b0;
            done_o    <= 1'b1;
            state     <= IDLE;
            if (!mem_we_o) begin
              wb_data_o <= load_val;
              wb_rd_o   <= rd_q;
              wb_en_o   <= (rd_q != 5'd0);
            end
          end else if (TIMEOUT > 0) begin
            if (cnt == TO_LAST) begin
              mem_req_o <= 1'b0;
              err_o     <= 1'b1;
              done_o    <= 1'b1;
              state     <= IDLE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mem_access.sv
// tb/tb_mem_access.sv - randomized self-checking bench for mem_access against a transaction-level model
`timescale 1ns/1ps
`ifndef RTYPE
`define RTYPE 5'b00001
`endif
`ifndef ITYPE
`define ITYPE 5'b00010
`endif
`ifndef STYPE
`define STYPE 5'b00100
`endif
`ifndef UTYPE
`define UTYPE 5'b01000
`endif
`ifndef LTYPE
`define LTYPE 5'b10000
`endif

module tb_mem_access;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  stage_i = 3'd0;
  logic [31:0] ir_i = 32'h0;
  logic [4:0]  itype_i = 5'd0;
  logic [31:0] y_i = 32'h0, pass_i = 32'h0;
  logic        mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic [3:0]  mem_wstrb_o;
  logic        mem_ack_i = 1'b0;
  logic [31:0] mem_rdata_i = 32'h0;
  logic        wb_en_o;
  logic [4:0]  wb_rd_o;
  logic [31:0] wb_data_o;
  logic        done_o, busy_o, err_o;

  mem_access #(.EXEC_STAGE(3'd4), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .stage_i(stage_i), .ir_i(ir_i), .itype_i(itype_i),
    .y_i(y_i), .pass_i(pass_i), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_wstrb_o(mem_wstrb_o),
    .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i), .wb_en_o(wb_en_o),
    .wb_rd_o(wb_rd_o), .wb_data_o(wb_data_o), .done_o(done_o), .busy_o(busy_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0;
  logic        exp_busy = 0, exp_req = 0, exp_done = 0, exp_err = 0, exp_wb_en = 0, exp_we = 0;
  logic [31:0] exp_addr = 0, exp_wdata = 0, exp_wb_data = 0;
  logic [3:0]  exp_wstrb = 0;
  logic [4:0]  exp_wb_rd = 0;

  int req_cycles = 0, wb_pulses = 0, done_pulses = 0, err_pulses = 0, errdone_same = 0;
  logic [31:0] last_addr = 0, last_wdata = 0, last_wb_data = 0;
  logic [3:0]  last_wstrb = 0;
  logic        last_we = 0;
  logic [4:0]  last_wb_rd = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      chk("busy", busy_o, exp_busy);
      chk("req", mem_req_o, exp_req);
      chk("done", done_o, exp_done);
      chk("err", err_o, exp_err);
      chk("wb_en", wb_en_o, exp_wb_en);
      if (exp_req) begin
        chk("we", mem_we_o, exp_we);
        chk("addr", mem_addr_o, exp_addr);
        chk("wdata", mem_wdata_o, exp_wdata);
        chk("wstrb", mem_wstrb_o, exp_wstrb);
      end
      if (exp_wb_en) begin
        chk("wb_rd", wb_rd_o, exp_wb_rd);
        chk("wb_data", wb_data_o, exp_wb_data);
      end
      if (mem_req_o) begin
        req_cycles++;
        last_addr = mem_addr_o; last_wdata = mem_wdata_o;
        last_wstrb = mem_wstrb_o; last_we = mem_we_o;
      end
      if (wb_en_o) begin
        wb_pulses++;
        last_wb_rd = wb_rd_o; last_wb_data = wb_data_o;
      end
      if (done_o) done_pulses++;
      if (err_o) err_pulses++;
      if (err_o && done_o) errdone_same++;
    end
  end

  function automatic int nbytes(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic logic model_bad(input logic [4:0] it, input logic [2:0] f3, input logic [31:0] y);
    if (it == `LTYPE && (f3 == 3 || f3 == 6 || f3 == 7)) return 1'b1;
    if (it == `STYPE && f3 >= 3) return 1'b1;
    return (y % nbytes(f3)) != 0;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] p);
    if (nbytes(f3) == 1) return {24'h0, p[7:0]} * 32'h0101_0101;
    if (nbytes(f3) == 2) return {16'h0, p[15:0]} * 32'h0001_0001;
    return p;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] y, input logic [31:0] rdata);
    int n;
    logic [31:0] v, mask;
    n = nbytes(f3);
    if (n == 4) return rdata;
    mask = (32'd1 << (8 * n)) - 32'd1;
    v = (rdata >> (8 * (y % 4))) & mask;
    if (!f3[2] && v[8 * n - 1]) v = v | ~mask;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic clr_pulses();
    exp_done = 0; exp_err = 0; exp_wb_en = 0;
  endtask

  // One instruction: dispatch, optional memory wait with ack after d cycles, then one stage-0 gap.
  task automatic do_op(input logic [4:0] it, input logic [2:0] f3, input logic [4:0] rd,
                       input logic [31:0] y, input logic [31:0] pass, input logic [31:0] rdata,
                       input int d, input int hold);
    logic [31:0] ir;
    logic is_mem, acked;
    int endk;
    ir = $urandom;
    ir[14:12] = f3;
    ir[11:7] = rd;
    is_mem = (it == `LTYPE) || (it == `STYPE);
    stage_i = 3'd4; itype_i = it; ir_i = ir; y_i = y; pass_i = pass; mem_ack_i = 0;
    step();
    clr_pulses();
    if (it == `RTYPE || it == `ITYPE) begin
      exp_done = 1; exp_wb_en = (rd != 0); exp_wb_rd = rd; exp_wb_data = y;
    end else if (!is_mem) begin
      exp_done = 1;
    end else if (model_bad(it, f3, y)) begin
      exp_done = 1; exp_err = 1;
    end else begin
      exp_req = 1; exp_busy = 1; exp_we = (it == `STYPE);
      exp_addr = y & 32'hFFFF_FFFC;
      exp_wdata = model_wdata(f3, pass);
      exp_wstrb = (it == `STYPE) ? 4'(((1 << nbytes(f3)) - 1) << (y % 4)) : 4'h0;
      acked = (d <= TO);
      endk = acked ? d : TO;
      for (int k = 1; k <= endk; k++) begin
        mem_ack_i = (k == d);
        mem_rdata_i = (k == d) ? rdata : $urandom;
        stage_i = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'd4;
        y_i = $urandom; pass_i = $urandom;
        step();
        clr_pulses();
        if (k == endk) begin
          exp_req = 0; exp_busy = 0; exp_done = 1; exp_err = !acked;
          if (acked && it == `LTYPE) begin
            exp_wb_en = (rd != 0); exp_wb_rd = rd; exp_wb_data = model_load(f3, y, rdata);
          end
        end
      end
      hold = 0;
    end
    mem_ack_i = 0;
    for (int h = 0; h < hold; h++) begin
      step();
      clr_pulses();
    end
    stage_i = 3'd0;
    mem_ack_i = $urandom_range(0, 1);
    mem_rdata_i = $urandom;
    step();
    clr_pulses();
    mem_ack_i = 0;
  endtask

  initial begin
    int w0, r0, d0, e0, s0;
    logic [4:0] its [5];
    its = '{`RTYPE, `ITYPE, `STYPE, `UTYPE, `LTYPE};

    #1;
    chk("rst_req", mem_req_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_wb_en", wb_en_o, 0);
    chk("rst_wb_data", wb_data_o, 0);
    chk("rst_addr", mem_addr_o, 0);
    chk("rst_wstrb", mem_wstrb_o, 0);
    step(); step();
    reset = 0;
    step();

    // ADD writeback with the stage held for three edges
    w0 = wb_pulses; r0 = req_cycles;
    do_op(`RTYPE, 3'd0, 5'd5, 32'h7, 32'h0, 32'h0, 1, 2);
    chk("add_pulses", wb_pulses - w0, 1);
    chk("add_rd", last_wb_rd, 5);
    chk("add_data", last_wb_data, 32'h7);
    chk("add_noreq", req_cycles - r0, 0);

    // LB / LBU
    do_op(`LTYPE, 3'd0, 5'd9, 32'h1003, 32'h0, 32'h80AB_CDEF, 2, 0);
    chk("lb_addr", last_addr, 32'h1000);
    chk("lb_data", last_wb_data, 32'hFFFF_FF80);
    do_op(`LTYPE, 3'd4, 5'd9, 32'h1003, 32'h0, 32'h80AB_CDEF, 2, 0);
    chk("lbu_data", last_wb_data, 32'h0000_0080);

    // SH upper half
    w0 = wb_pulses;
    do_op(`STYPE, 3'd1, 5'd4, 32'h2002, 32'h1234_BEEF, 32'h0, 1, 0);
    chk("sh_we", last_we, 1);
    chk("sh_wstrb", last_wstrb, 4'b1100);
    chk("sh_wdata", last_wdata, 32'hBEEF_BEEF);
    chk("sh_nowb", wb_pulses - w0, 0);

    // misaligned LW
    r0 = req_cycles; e0 = err_pulses; s0 = errdone_same;
    do_op(`LTYPE, 3'd2, 5'd3, 32'h1, 32'h0, 32'h0, 1, 0);
    chk("mis_noreq", req_cycles - r0, 0);
    chk("mis_errdone", errdone_same - s0, 1);

    // timeout
    r0 = req_cycles; e0 = err_pulses; w0 = wb_pulses;
    do_op(`LTYPE, 3'd2, 5'd3, 32'h40, 32'h0, 32'h0, 100, 0);
    chk("to_req_cycles", req_cycles - r0, TO);
    chk("to_err", err_pulses - e0, 1);
    chk("to_nowb", wb_pulses - w0, 0);

    // reset while a load is waiting
    stage_i = 3'd4; itype_i = `LTYPE; ir_i = 32'h0000_2183; y_i = 32'h80; mem_ack_i = 0;
    step();
    clr_pulses();
    exp_req = 1; exp_busy = 1; exp_we = 0; exp_addr = 32'h80;
    exp_wdata = model_wdata(3'd2, pass_i); exp_wstrb = 4'h0;
    @(negedge clk);
    #2;
    reset = 1;
    #1;
    chk("rst_mid_req", mem_req_o, 0);
    chk("rst_mid_busy", busy_o, 0);
    exp_req = 0; exp_busy = 0;
    step();
    reset = 0; stage_i = 3'd0;
    d0 = done_pulses; w0 = wb_pulses;
    mem_ack_i = 1; mem_rdata_i = 32'h1234_5678;
    step();
    mem_ack_i = 0;
    step();
    chk("late_ack_done", done_pulses - d0, 0);
    chk("late_ack_wb", wb_pulses - w0, 0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      logic [4:0] it;
      logic [31:0] y;
      it = ($urandom_range(0, 9) == 0) ? 5'($urandom) : its[$urandom_range(0, 4)];
      y = $urandom;
      if ($urandom_range(0, 1) == 1) y[1:0] = 2'b00;
      do_op(it, 3'($urandom), ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom),
            y, $urandom, $urandom, $urandom_range(1, TO + 2), $urandom_range(0, 2));
    end

    step();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", n_err + 1, n_chk + 1);
    $finish;
  end
endmodule
